seg_scan_driver: RTL and testbench

Four-digit multiplexed 7-segment display driver that sits directly downstream of the mod-60 BCD counter. It consumes the counter's ones/tens digits, plus an upper pair of BCD digits (the next counter in the chain), and scans them onto a common-anode display. It snapshots all digits once per frame so the display never tears mid-scan. It also flashes a decimal point for a programmable number of frames whenever the counter reports carry-out.

---
 rtl/seg_scan_driver.sv | 128 ++++++++++++
 tb/tb_seg_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-segment scanner with per-frame digit snapshot and carry dp flash.
// Outputs registered, 1-cycle latency from idx/snapshot; en=0 freezes the scan and blanks the display.
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int DP_HOLD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hi_ones,
    input  logic [3:0] hi_tens,
    input  logic       co,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int              PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0]      FL_LOAD   = 8'(DP_HOLD);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    fl_q, fl_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ftick_q, ftick_d;

    logic          tc;
    logic          frame_start;
    logic          blank3;
    logic          blank2;
    logic          blank_cur;
    logic [3:0]    cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tc          = en && (pcnt_q == PCNT_LAST);
        frame_start = tc && (idx_q == 2'd3);

        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        if (en) begin
            pcnt_d = tc ? '0 : pcnt_q + PW'(1);
        end
        if (tc) begin
            idx_d = idx_q + 2'd1;
        end

        snap_d = frame_start ? {hi_tens, hi_ones, tens, ones} : snap_q;

        // A carry load on a frame-start edge takes priority over the decrement.
        fl_d = fl_q;
        if (en && co) begin
            fl_d = FL_LOAD;
        end else if (frame_start && (fl_q != 8'd0)) begin
            fl_d = fl_q - 8'd1;
        end

        ftick_d = frame_start;

        blank3    = blank_lead && (snap_q[15:12] == 4'd0);
        blank2    = blank3 && (snap_q[11:8] == 4'd0);
        cur_digit = snap_q[{idx_q, 2'b00} +: 4];
        blank_cur = ((idx_q == 2'd3) && blank3) || ((idx_q == 2'd2) && blank2);

        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (en) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank_cur ? SEG_BLANK : seg_decode(cur_digit);
            dp_d  = !((idx_q == 2'd2) || ((idx_q == 2'd0) && (fl_q != 8'd0)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_q  <= '0;
            idx_q   <= 2'd0;
            fl_q    <= 8'd0;
            snap_q  <= 16'd0;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            ftick_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            fl_q    <= fl_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ftick_q <= ftick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, DP_HOLD=2; all checks go through chk().
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ones, tens, hi_ones, hi_tens;
    logic       co;
    logic       blank_lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_chk  = 0;
    int n_fail = 0;

    seg_scan_driver #(.SCAN_DIV(4), .DP_HOLD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ones       (ones),
        .tens       (tens),
        .hi_ones    (hi_ones),
        .hi_tens    (hi_tens),
        .co         (co),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("frame_tick_seen", frame_tick, 1);
    endtask

    // Waits for a frame start, then samples each digit's first displayed cycle.
    task automatic frame_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic d0);
        logic [6:0] s [4];
        logic       exp_dp;
        logic [3:0] exp_an;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        wait_tick();
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? 1 : 4);
            exp_an = ~(4'b0001 << k);
            exp_dp = (k == 2) ? 1'b0 : ((k == 0) ? d0 : 1'b1);
            chk($sformatf("%s_an%0d", tag, k), an, exp_an);
            chk($sformatf("%s_seg%0d", tag, k), seg, s[k]);
            chk($sformatf("%s_dp%0d", tag, k), dp, exp_dp);
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        logic [3:0] resume_an [4];

        rst = 1'b0; en = 1'b0; co = 1'b0; blank_lead = 1'b0;
        ones = 4'd0; tens = 4'd0; hi_ones = 4'd0; hi_tens = 4'd0;

        // Reset and idle scan of an all-zero snapshot.
        step(3);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_tick", frame_tick, 0);
        rst = 1'b1; en = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_an = ~(4'b0001 << ((c - 1) / 4));
            chk($sformatf("idle_an_c%0d", c), an, exp_an);
            chk($sformatf("idle_seg_c%0d", c), seg, 7'h40);
            chk($sformatf("idle_dp_c%0d", c), dp, (((c - 1) / 4) == 2) ? 0 : 1);
            chk($sformatf("idle_tick_c%0d", c), frame_tick, (c == 16) ? 1 : 0);
        end

        // Mid-frame input change stays hidden until the next frame start.
        step(5);
        ones = 4'd7; tens = 4'd5; hi_ones = 4'd3; hi_tens = 4'd1;
        step(4);
        chk("snap_old_an2", an, 4'hB);
        chk("snap_old_seg2", seg, 7'h40);
        step(4);
        chk("snap_old_an3", an, 4'h7);
        chk("snap_old_seg3", seg, 7'h40);
        frame_check("snap_new", 7'h78, 7'h12, 7'h30, 7'h79, 1'b1);

        // Leading-zero blanking.
        blank_lead = 1'b1; hi_tens = 4'd0; hi_ones = 4'd0; tens = 4'd0; ones = 4'd4;
        frame_check("blank_both", 7'h19, 7'h40, 7'h7F, 7'h7F, 1'b1);
        hi_ones = 4'd2;
        frame_check("blank_hi", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b1);

        // Single carry mid-frame: one lit frame.
        co = 1'b1; step(); co = 1'b0;
        frame_check("co1_a", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b0);
        frame_check("co1_b", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b1);

        // Second carry before expiry reloads the count.
        co = 1'b1; step(); co = 1'b0;
        frame_check("co2_a", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b0);
        co = 1'b1; step(); co = 1'b0;
        frame_check("co2_b", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b0);
        frame_check("co2_c", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b1);

        // Carry on the frame-start edge with fl already 2: load beats decrement.
        co = 1'b1; step(); co = 1'b0;
        step();
        co = 1'b1; step(); co = 1'b0;
        chk("co_fs_tick", frame_tick, 1);
        frame_check("co_fs_a", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b0);
        frame_check("co_fs_b", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b0);
        frame_check("co_fs_c", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b1);

        // Enable gating at idx=2, pcnt=1; carry during the gap is ignored.
        wait_tick();
        step(9);
        en = 1'b0; co = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("dis_an_%0d", i), an, 4'hF);
            chk($sformatf("dis_seg_%0d", i), seg, 7'h7F);
            chk($sformatf("dis_dp_%0d", i), dp, 1);
            chk($sformatf("dis_tick_%0d", i), frame_tick, 0);
        end
        co = 1'b0; en = 1'b1;
        resume_an[0] = 4'hB; resume_an[1] = 4'hB; resume_an[2] = 4'hB; resume_an[3] = 4'h7;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("resume_an_%0d", i), an, resume_an[i]);
        end
        frame_check("en_resume", 7'h19, 7'h40, 7'h24, 7'h7F, 1'b1);

        // Non-BCD digit shows a dash; other codes decoded.
        blank_lead = 1'b0; ones = 4'hC; tens = 4'd9; hi_ones = 4'd8; hi_tens = 4'd6;
        frame_check("bad_bcd", 7'h3F, 7'h10, 7'h00, 7'h02, 1'b1);

        // Reset mid-frame.
        rst = 1'b0;
        step();
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_dp", dp, 1);
        chk("mid_rst_tick", frame_tick, 0);
        rst = 1'b1;
        step();
        chk("post_rst_an", an, 4'hE);
        chk("post_rst_seg", seg, 7'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
